// File: rtl/scsi_pack_fifo.sv
// SCSI byte <-> host word packing FIFO.
// Pack mode (DMADIR=0) assembles SCSI bytes into big-endian host words.
// Unpack mode (DMADIR=1) streams host words out as SCSI bytes.
// FLUSH pushes a partial word in pack mode and discards the FIFO in unpack mode.
module scsi_pack_fifo #(
   parameter int BUS_BYTES = 4,
   parameter int DEPTH     = 8
) (
   input  logic                         CLK,
   input  logic                         nRESET,
   input  logic                         DMADIR,
   input  logic                         FLUSH,
   input  logic [7:0]                   PD_IN,
   input  logic                         PD_IN_VLD,
   output logic                         PD_IN_RDY,
   output logic [7:0]                   PD_OUT,
   output logic                         PD_OUT_VLD,
   input  logic                         PD_OUT_RDY,
   input  logic [8*BUS_BYTES-1:0]       WD_IN,
   input  logic                         WD_IN_VLD,
   output logic                         WD_IN_RDY,
   output logic [8*BUS_BYTES-1:0]       WD_OUT,
   output logic [BUS_BYTES-1:0]         WD_OUT_BE,
   output logic                         WD_OUT_VLD,
   input  logic                         WD_OUT_RDY,
   output logic [$clog2(DEPTH):0]       LEVEL,
   output logic                         FULL,
   output logic                         EMPTY,
   output logic [$clog2(BUS_BYTES)-1:0] BO,
   output logic                         FLUSH_DONE
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(BUS_BYTES);
   localparam int DW = 8 * BUS_BYTES;
   localparam logic [BW-1:0]        LAST_LANE = BW'(BUS_BYTES - 1);
   localparam logic [BW-1:0]        BO_ONE    = BW'(1);
   localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
   localparam logic [LW-1:0]        LVL_ONE   = LW'(1);
   localparam logic [LW-1:0]        LVL_FULL  = LW'(DEPTH);
   localparam logic [BUS_BYTES-1:0] BE_ALL    = {BUS_BYTES{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_FLUSH_WAIT = 2'd1,
      ST_FLUSH_ACK  = 2'd2
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_dir;
   logic [BW-1:0]          r_bo, w_bo_nxt;
   logic [DW-1:0]          r_pack, w_pack_nxt;
   logic [AW-1:0]          r_wptr, r_rptr;
   logic [LW-1:0]          r_level;
   logic [DW-1:0]          r_mem_data [DEPTH];
   logic [BUS_BYTES-1:0]   r_mem_be   [DEPTH];

   logic                   w_full, w_empty, w_last, w_run;
   logic                   w_pd_in_acc, w_pd_out_acc, w_wd_in_acc, w_wd_out_acc;
   logic                   w_push, w_pop, w_clear;
   logic [DW-1:0]          w_push_data, w_pack_word, w_head_data;
   logic [BUS_BYTES-1:0]   w_push_be;

   // Replace byte lane 'lane' (lane 0 = most significant) of a word.
   function automatic logic [DW-1:0] f_lane_wr(input logic [DW-1:0] w,
                                               input logic [BW-1:0] lane,
                                               input logic [7:0]    b);
      logic [DW-1:0] r;
      r = w;
      for (int i = 0; i < BUS_BYTES; i++) begin
         if (BW'(i) == lane) r[8*(BUS_BYTES-1-i) +: 8] = b;
      end
      return r;
   endfunction

   // Extract byte lane 'lane' (lane 0 = most significant) of a word.
   function automatic logic [7:0] f_lane_rd(input logic [DW-1:0] w,
                                            input logic [BW-1:0] lane);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < BUS_BYTES; i++) begin
         if (BW'(i) == lane) r = w[8*(BUS_BYTES-1-i) +: 8];
      end
      return r;
   endfunction

   // Byte enables for lanes 0..n-1 (lane 0 maps to the MSB of BE).
   function automatic logic [BUS_BYTES-1:0] f_be_prefix(input logic [BW-1:0] n);
      logic [BUS_BYTES-1:0] r;
      for (int i = 0; i < BUS_BYTES; i++) begin
         r[BUS_BYTES-1-i] = (BW'(i) < n);
      end
      return r;
   endfunction

   assign w_full       = (r_level == LVL_FULL);
   assign w_empty      = (r_level == {LW{1'b0}});
   assign w_last       = (r_bo == LAST_LANE);
   assign w_run        = (r_state == ST_RUN);
   assign w_head_data  = r_mem_data[r_rptr];
   assign w_pack_word  = f_lane_wr(r_pack, r_bo, PD_IN);

   // Handshake outputs are held low while reset is asserted.
   assign PD_IN_RDY    = nRESET & ~DMADIR & w_run & ~(w_last & w_full);
   assign WD_IN_RDY    = nRESET & DMADIR & ~w_full & w_run;
   assign WD_OUT_VLD   = nRESET & ~DMADIR & ~w_empty;
   assign PD_OUT_VLD   = nRESET & DMADIR & ~w_empty;
   assign WD_OUT       = w_empty ? {DW{1'b0}} : w_head_data;
   assign WD_OUT_BE    = w_empty ? {BUS_BYTES{1'b0}} : r_mem_be[r_rptr];
   assign PD_OUT       = w_empty ? 8'h00 : f_lane_rd(w_head_data, r_bo);
   assign LEVEL        = r_level;
   assign FULL         = w_full;
   assign EMPTY        = w_empty;
   assign BO           = r_bo;
   assign FLUSH_DONE   = (r_state == ST_FLUSH_ACK);

   assign w_pd_in_acc  = PD_IN_VLD & PD_IN_RDY;
   assign w_pd_out_acc = PD_OUT_VLD & PD_OUT_RDY;
   assign w_wd_in_acc  = WD_IN_VLD & WD_IN_RDY;
   assign w_wd_out_acc = WD_OUT_VLD & WD_OUT_RDY;

   // Controller next state plus push/pop/clear and lane-pointer decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_bo_nxt    = r_bo;
      w_pack_nxt  = r_pack;
      w_push      = 1'b0;
      w_push_data = {DW{1'b0}};
      w_push_be   = {BUS_BYTES{1'b0}};
      w_pop       = 1'b0;
      w_clear     = 1'b0;
      if (DMADIR != r_dir) begin
         // Direction change: drop everything and restart, no flush handshake.
         w_clear     = 1'b1;
         w_bo_nxt    = {BW{1'b0}};
         w_pack_nxt  = {DW{1'b0}};
         w_state_nxt = ST_RUN;
      end else if (!DMADIR) begin
         w_pop = w_wd_out_acc;
         if (w_pd_in_acc) begin
            w_bo_nxt = r_bo + BO_ONE;
            if (w_last) begin
               w_push      = 1'b1;
               w_push_data = w_pack_word;
               w_push_be   = BE_ALL;
               w_pack_nxt  = {DW{1'b0}};
            end else begin
               w_pack_nxt  = w_pack_word;
            end
         end else begin
            w_bo_nxt = r_bo;
         end
         case (r_state)
            ST_RUN: begin
               // A byte accepted alongside FLUSH is counted before deciding.
               if (FLUSH) begin
                  w_state_nxt = (w_bo_nxt != {BW{1'b0}}) ? ST_FLUSH_WAIT : ST_FLUSH_ACK;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_FLUSH_WAIT: begin
               if (!w_full) begin
                  w_push      = 1'b1;
                  w_push_data = r_pack;
                  w_push_be   = f_be_prefix(r_bo);
                  w_bo_nxt    = {BW{1'b0}};
                  w_pack_nxt  = {DW{1'b0}};
                  w_state_nxt = ST_FLUSH_ACK;
               end else begin
                  w_state_nxt = ST_FLUSH_WAIT;
               end
            end
            ST_FLUSH_ACK: w_state_nxt = ST_RUN;
            default:      w_state_nxt = ST_RUN;
         endcase
      end else begin
         w_push      = w_wd_in_acc;
         w_push_data = WD_IN;
         w_push_be   = BE_ALL;
         if (w_pd_out_acc) begin
            w_bo_nxt = w_last ? {BW{1'b0}} : (r_bo + BO_ONE);
            w_pop    = w_last;
         end else begin
            w_bo_nxt = r_bo;
            w_pop    = 1'b0;
         end
         case (r_state)
            ST_RUN: begin
               if (FLUSH) begin
                  w_clear     = 1'b1;
                  w_bo_nxt    = {BW{1'b0}};
                  w_state_nxt = ST_FLUSH_ACK;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_FLUSH_WAIT: w_state_nxt = ST_RUN;
            ST_FLUSH_ACK:  w_state_nxt = ST_RUN;
            default:       w_state_nxt = ST_RUN;
         endcase
      end
   end

   // Control registers: state, direction copy, lane pointer, partial word, FIFO pointers.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= ST_RUN;
         r_dir   <= 1'b0;
         r_bo    <= {BW{1'b0}};
         r_pack  <= {DW{1'b0}};
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_level <= {LW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= DMADIR;
         r_bo    <= w_bo_nxt;
         r_pack  <= w_pack_nxt;
         if (w_clear) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_level <= {LW{1'b0}};
         end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + LVL_ONE;
               2'b01:   r_level <= r_level - LVL_ONE;
               default: r_level <= r_level;
            endcase
         end
      end
   end

   // FIFO storage; contents are qualified by LEVEL so no reset is needed.
   always_ff @(posedge CLK) begin
      if (w_push && !w_clear) begin
         r_mem_data[r_wptr] <= w_push_data;
         r_mem_be[r_wptr]   <= w_push_be;
      end
   end
endmodule

// File: tb/tb_scsi_pack_fifo.sv
// Scoreboard bench for scsi_pack_fifo (BUS_BYTES=4, DEPTH=8).
module tb_scsi_pack_fifo;
   localparam int BB    = 4;
   localparam int DEPTH = 8;

   logic        CLK = 1'b0, nRESET = 1'b0, DMADIR = 1'b0, FLUSH = 1'b0;
   logic [7:0]  PD_IN = 8'h00, PD_OUT;
   logic        PD_IN_VLD = 1'b0, PD_IN_RDY, PD_OUT_VLD, PD_OUT_RDY = 1'b0;
   logic [31:0] WD_IN = 32'h0, WD_OUT;
   logic        WD_IN_VLD = 1'b0, WD_IN_RDY, WD_OUT_VLD, WD_OUT_RDY = 1'b0;
   logic [3:0]  WD_OUT_BE, LEVEL;
   logic        FULL, EMPTY, FLUSH_DONE;
   logic [1:0]  BO;

   int n_cmp = 0, n_mis = 0;

   // Reference model state: pending pack bytes, expected words, expected bytes.
   logic [7:0]  m_pend[$];
   logic [35:0] m_words[$];
   logic [7:0]  m_bytes[$];
   logic        m_dir = 1'b0;
   logic [35:0] mon_w;
   logic [7:0]  mon_b;

   scsi_pack_fifo #(.BUS_BYTES(BB), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .nRESET(nRESET), .DMADIR(DMADIR), .FLUSH(FLUSH),
      .PD_IN(PD_IN), .PD_IN_VLD(PD_IN_VLD), .PD_IN_RDY(PD_IN_RDY),
      .PD_OUT(PD_OUT), .PD_OUT_VLD(PD_OUT_VLD), .PD_OUT_RDY(PD_OUT_RDY),
      .WD_IN(WD_IN), .WD_IN_VLD(WD_IN_VLD), .WD_IN_RDY(WD_IN_RDY),
      .WD_OUT(WD_OUT), .WD_OUT_BE(WD_OUT_BE), .WD_OUT_VLD(WD_OUT_VLD), .WD_OUT_RDY(WD_OUT_RDY),
      .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .BO(BO), .FLUSH_DONE(FLUSH_DONE)
   );

   always #5 CLK = ~CLK;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Big-endian word from the pending bytes; BE marks the lanes that hold data.
   function automatic logic [35:0] pend_word();
      logic [31:0] d;
      logic [3:0]  be;
      d  = 32'h0;
      be = 4'h0;
      for (int i = 0; i < m_pend.size(); i++) begin
         d[8*(BB-1-i) +: 8] = m_pend[i];
         be[BB-1-i]         = 1'b1;
      end
      return {be, d};
   endfunction

   // Reference model: converts accepted inputs into expected outputs.
   always @(negedge CLK) begin
      if (!nRESET) begin
         m_pend.delete(); m_words.delete(); m_bytes.delete(); m_dir = 1'b0;
      end else if (DMADIR != m_dir) begin
         m_pend.delete(); m_words.delete(); m_bytes.delete(); m_dir = DMADIR;
      end else if (!DMADIR) begin
         if (PD_IN_VLD && PD_IN_RDY) begin
            m_pend.push_back(PD_IN);
            if (m_pend.size() == BB) begin
               m_words.push_back(pend_word());
               m_pend.delete();
            end
         end
         if (FLUSH && m_pend.size() != 0) begin
            m_words.push_back(pend_word());
            m_pend.delete();
         end
      end else begin
         if (WD_IN_VLD && WD_IN_RDY)
            for (int i = 0; i < BB; i++) m_bytes.push_back(WD_IN[8*(BB-1-i) +: 8]);
         if (FLUSH) m_bytes.delete();
      end
   end

   // Monitor: compares each output transfer with the oldest expectation.
   always @(negedge CLK) begin
      if (nRESET) begin
         chk("full_vs_level", FULL, (LEVEL == DEPTH));
         chk("empty_vs_level", EMPTY, (LEVEL == 0));
         chk("wd_out_vld", WD_OUT_VLD, (!EMPTY && !DMADIR));
         if (EMPTY) chk("empty_out_zero", {WD_OUT_BE, WD_OUT}, 36'h0);
         if (WD_OUT_VLD && WD_OUT_RDY) begin
            if (m_words.size() == 0) begin
               n_cmp++; n_mis++;
               $display("FAIL unexpected_word: got %h/%h with nothing expected", WD_OUT_BE, WD_OUT);
            end else begin
               mon_w = m_words.pop_front();
               chk("wd_out_word", {WD_OUT_BE, WD_OUT}, mon_w);
            end
         end
         if (PD_OUT_VLD && PD_OUT_RDY) begin
            if (m_bytes.size() == 0) begin
               n_cmp++; n_mis++;
               $display("FAIL unexpected_byte: got %h with nothing expected", PD_OUT);
            end else begin
               mon_b = m_bytes.pop_front();
               chk("pd_out_byte", PD_OUT, mon_b);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      PD_IN = b; PD_IN_VLD = 1'b1;
      @(negedge CLK);
      while (!PD_IN_RDY && n < 200) begin n++; @(negedge CLK); end
      if (!PD_IN_RDY) begin n_cmp++; n_mis++; $display("FAIL send_byte_timeout: byte %h never accepted", b); end
      @(posedge CLK); #1;
      PD_IN_VLD = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      WD_IN = w; WD_IN_VLD = 1'b1;
      @(negedge CLK);
      while (!WD_IN_RDY && n < 200) begin n++; @(negedge CLK); end
      if (!WD_IN_RDY) begin n_cmp++; n_mis++; $display("FAIL send_word_timeout: word %h never accepted", w); end
      @(posedge CLK); #1;
      WD_IN_VLD = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      PD_IN_VLD = 1'b0; WD_IN_VLD = 1'b0; WD_OUT_RDY = 1'b1; PD_OUT_RDY = 1'b1;
      while (!EMPTY && n < 300) begin n++; tick(); end
      chk("drain_empty", EMPTY, 1'b1);
      WD_OUT_RDY = 1'b0; PD_OUT_RDY = 1'b0;
   endtask

   task automatic set_dir(input logic d);
      PD_IN_VLD = 1'b0; WD_IN_VLD = 1'b0; PD_OUT_RDY = 1'b0; WD_OUT_RDY = 1'b0;
      DMADIR = d;
      tick();
      chk("dir_level", LEVEL, 4'd0);
      chk("dir_bo", BO, 2'd0);
   endtask

   task automatic do_flush();
      int n = 0;
      PD_OUT_RDY = 1'b0; FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0; PD_IN_VLD = 1'b0; WD_IN_VLD = 1'b0; WD_OUT_RDY = 1'b1;
      while (!FLUSH_DONE && n < 100) begin n++; tick(); end
      chk("flush_done_seen", FLUSH_DONE, 1'b1);
      tick();
      chk("flush_done_pulse", FLUSH_DONE, 1'b0);
   endtask

   logic [7:0] exp44 [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with handshakes quiet.
      #3;
      chk("rst_level", LEVEL, 4'd0);
      chk("rst_flags", {FULL, EMPTY, FLUSH_DONE}, 3'b010);
      chk("rst_bo", BO, 2'd0);
      chk("rst_hs", {PD_IN_RDY, PD_OUT_VLD, WD_IN_RDY, WD_OUT_VLD}, 4'b0000);
      tick(2);
      nRESET = 1'b1;
      tick();

      // One packed word appears the cycle after the last byte.
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      chk("pack_word", WD_OUT, 32'h11223344);
      chk("pack_be", WD_OUT_BE, 4'hF);
      chk("pack_level", LEVEL, 4'd1);
      chk("pack_vld", WD_OUT_VLD, 1'b1);
      drain();

      // Fill the FIFO, then stall the 4th byte of the next word until a pop.
      for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'($urandom));
      chk("fill_full", FULL, 1'b1);
      chk("fill_level", LEVEL, 4'd8);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom));
      PD_IN = 8'h5A; PD_IN_VLD = 1'b1;
      @(negedge CLK);
      chk("stall_rdy", PD_IN_RDY, 1'b0);
      chk("stall_bo", BO, 2'd3);
      @(posedge CLK); #1;
      WD_OUT_RDY = 1'b1;
      @(posedge CLK); #1;
      WD_OUT_RDY = 1'b0;
      chk("pop_level", LEVEL, 4'd7);
      @(negedge CLK);
      chk("unstall_rdy", PD_IN_RDY, 1'b1);
      @(posedge CLK); #1;
      PD_IN_VLD = 1'b0;
      chk("refill_level", LEVEL, 4'd8);
      chk("refill_bo", BO, 2'd0);
      drain();

      // Partial-word flush, then flush at a word boundary.
      send_byte(8'hAA); send_byte(8'hBB);
      FLUSH = 1'b1; tick(); FLUSH = 1'b0;
      chk("flush_wait_done", FLUSH_DONE, 1'b0);
      tick();
      chk("flush_done", FLUSH_DONE, 1'b1);
      chk("flush_word", WD_OUT, 32'hAABB0000);
      chk("flush_be", WD_OUT_BE, 4'b1100);
      chk("flush_bo", BO, 2'd0);
      tick();
      chk("flush_done_low", FLUSH_DONE, 1'b0);
      FLUSH = 1'b1; tick(); FLUSH = 1'b0;
      chk("flush0_done", FLUSH_DONE, 1'b1);
      chk("flush0_level", LEVEL, 4'd1);
      tick();
      chk("flush0_done_low", FLUSH_DONE, 1'b0);
      drain();

      // A byte presented with FLUSH is part of the flushed word.
      send_byte(8'hDD);
      PD_IN = 8'hCC; PD_IN_VLD = 1'b1; FLUSH = 1'b1;
      tick();
      PD_IN_VLD = 1'b0; FLUSH = 1'b0;
      tick();
      chk("flush_byte_done", FLUSH_DONE, 1'b1);
      chk("flush_byte_word", {WD_OUT_BE, WD_OUT}, {4'b1100, 32'hDDCC0000});
      drain();

      // Random pack traffic with periodic flushes.
      for (int i = 0; i < 400; i++) begin
         PD_IN = 8'($urandom); PD_IN_VLD = ($urandom_range(0, 3) != 0);
         WD_OUT_RDY = ($urandom_range(0, 2) == 0);
         if (i % 50 == 49) do_flush(); else tick();
      end
      drain();

      // Unpack one word: bytes on consecutive cycles, MSB first.
      set_dir(1'b1);
      exp44[0] = 8'hDE; exp44[1] = 8'hAD; exp44[2] = 8'hBE; exp44[3] = 8'hEF;
      PD_OUT_RDY = 1'b1;
      send_word(32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("unpack_vld", PD_OUT_VLD, 1'b1);
         chk("unpack_byte", PD_OUT, exp44[i]);
         @(posedge CLK); #1;
      end
      chk("unpack_empty", EMPTY, 1'b1);
      chk("unpack_bo", BO, 2'd0);
      PD_OUT_RDY = 1'b0;

      // Random unpack traffic with periodic flushes.
      for (int i = 0; i < 400; i++) begin
         WD_IN = $urandom; WD_IN_VLD = ($urandom_range(0, 1) != 0);
         PD_OUT_RDY = ($urandom_range(0, 3) != 0);
         if (i % 70 == 69) do_flush(); else tick();
      end
      drain();

      // Direction change discards five words without a flush handshake.
      for (int i = 0; i < 5; i++) send_word($urandom);
      chk("load5_level", LEVEL, 4'd5);
      PD_OUT_RDY = 1'b1; tick(); PD_OUT_RDY = 1'b0;
      chk("load5_bo", BO, 2'd1);
      DMADIR = 1'b0;
      tick();
      chk("toggle_level", LEVEL, 4'd0);
      chk("toggle_bo", BO, 2'd0);
      chk("toggle_no_done", FLUSH_DONE, 1'b0);
      tick();
      chk("toggle_no_done2", FLUSH_DONE, 1'b0);

      // Unpack flush empties the FIFO and acknowledges.
      set_dir(1'b1);
      for (int i = 0; i < 3; i++) send_word($urandom);
      FLUSH = 1'b1; tick(); FLUSH = 1'b0;
      chk("uflush_level", LEVEL, 4'd0);
      chk("uflush_done", FLUSH_DONE, 1'b1);
      tick();
      chk("uflush_done_low", FLUSH_DONE, 1'b0);

      // Reset mid-word abandons the partial word and clears the FIFO.
      set_dir(1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      send_byte(8'h01); send_byte(8'h02);
      #3 nRESET = 1'b0;
      #1;
      chk("midrst_level", LEVEL, 4'd0);
      chk("midrst_bo", BO, 2'd0);
      chk("midrst_empty", EMPTY, 1'b1);
      chk("midrst_rdy", PD_IN_RDY, 1'b0);
      @(posedge CLK); #1;
      nRESET = 1'b1;
      tick();
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
      chk("postrst_word", {WD_OUT_BE, WD_OUT}, {4'hF, 32'hA1A2A3A4});
      chk("postrst_level", LEVEL, 4'd1);
      drain();
      tick(2);

      chk("left_words", m_words.size(), 0);
      chk("left_bytes", m_bytes.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/scsi_pack_fifo.md
SCSI_PACK_FIFO -- requirements
Module: scsi_pack_fifo

Interface
REQ-001 SHALL have parameter BUS_BYTES, default 4, host word width in bytes (2, 4 or 8).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO depth in host words (power of 2, >=2).
REQ-003 SHALL have port CLK, input, 1, the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port DMADIR, input, 1: 0 = SCSI-to-host (pack); 1 = host-to-SCSI (unpack).
REQ-006 SHALL have port FLUSH, input, 1, single-cycle flush request.
REQ-007 SHALL have ports PD_IN (input, 8), PD_IN_VLD (input, 1) and PD_IN_RDY (output, 1), the SCSI byte-in handshake.
REQ-008 SHALL have ports PD_OUT (output, 8), PD_OUT_VLD (output, 1) and PD_OUT_RDY (input, 1), the SCSI byte-out handshake.
REQ-009 SHALL have ports WD_IN (input, 8*BUS_BYTES), WD_IN_VLD (input, 1) and WD_IN_RDY (output, 1), the host word-in handshake.
REQ-010 SHALL have ports WD_OUT (output, 8*BUS_BYTES), WD_OUT_BE (output, BUS_BYTES), WD_OUT_VLD (output, 1) and WD_OUT_RDY (input, 1), the host word-out handshake with byte enables.
REQ-011 SHALL have status outputs LEVEL (clog2(DEPTH)+1 bits, words held), FULL (1), EMPTY (1), BO (clog2(BUS_BYTES) bits, byte pointer) and FLUSH_DONE (1, pulse).

Function
REQ-012 A transfer SHALL occur only on a clock edge where VLD and RDY are both high.
REQ-013 Byte order SHALL be big-endian: BO=0 is the most significant lane.
REQ-014 Pack mode SHALL write each accepted PD_IN byte into lane BO, then set BO to BO+1 mod BUS_BYTES.
REQ-015 In pack mode, the edge that accepts the last byte (BO=BUS_BYTES-1) SHALL push the assembled word into the FIFO with BE all ones.
REQ-016 PD_IN_RDY SHALL be the expression: DMADIR=0, AND state RUN, AND NOT (BO=BUS_BYTES-1 AND FULL).
REQ-017 The FIFO SHALL be first-word-fall-through: WD_OUT/WD_OUT_BE equal the head entry; WD_OUT_VLD = NOT EMPTY AND DMADIR=0.
REQ-018 When EMPTY, WD_OUT and WD_OUT_BE SHALL be zero.
REQ-019 In pack mode, word latency SHALL be one cycle: WD_OUT_VLD rises on the edge that accepts the last byte, if the FIFO was empty.
REQ-020 Unpack mode SHALL push WD_IN into the FIFO with BE all ones; WD_IN_RDY = DMADIR=1 AND NOT FULL AND state RUN.
REQ-021 In unpack mode, PD_OUT SHALL be lane BO of the head word; PD_OUT_VLD = DMADIR=1 AND NOT EMPTY.
REQ-022 In unpack mode, each accepted byte SHALL increment BO.
REQ-023 In unpack mode, the edge that accepts lane BUS_BYTES-1 SHALL pop the head word and set BO to 0.
REQ-024 Push SHALL require NOT FULL, and pop SHALL require NOT EMPTY.
REQ-025 A simultaneous push and pop SHALL leave LEVEL unchanged, including at LEVEL=DEPTH-1 and LEVEL=1.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 FULL SHALL be asserted exactly when LEVEL=DEPTH, and EMPTY exactly when LEVEL=0.
REQ-028 The controller SHALL have three states: RUN, FLUSH_WAIT and FLUSH_ACK.
REQ-029 RUN->FLUSH_WAIT SHALL occur when FLUSH=1 in pack mode with BO!=0.
REQ-030 RUN->FLUSH_ACK SHALL occur when FLUSH=1 in pack mode with BO=0.
REQ-031 In FLUSH_WAIT, when NOT FULL, the block SHALL push the partial word: unfilled lanes zero, BE bits set for lanes 0..BO-1 only; BO->0; state->FLUSH_ACK.
REQ-032 FLUSH_ACK SHALL drive FLUSH_DONE=1 for exactly one cycle, then return to RUN.
REQ-033 FLUSH in unpack mode SHALL discard all FIFO contents, set BO=0 and go to FLUSH_ACK.
REQ-034 FLUSH while not in RUN SHALL be ignored.
REQ-035 A change of DMADIR (compared against a registered copy) SHALL, on the next edge, clear the FIFO, set BO=0 and force state RUN, with no FLUSH_DONE.
REQ-036 A PD_IN byte presented in the same cycle as FLUSH SHALL be accepted first; the flush then includes it.

Reset
REQ-037 On nRESET low, asynchronously: LEVEL=0, EMPTY=1, FULL=0, BO=0, state=RUN, FLUSH_DONE=0, registered DMADIR=0, and pointers=0.
REQ-038 FIFO storage SHALL NOT require reset.
REQ-039 During reset, all VLD/RDY outputs SHALL be 0.
REQ-040 Reset asserted mid-transfer SHALL abandon any partial word, with no push.

Verification (BUS_BYTES=4, DEPTH=8)
REQ-041 Pack bytes 11,22,33,44 -> next cycle WD_OUT=11223344, BE=1111, LEVEL=1.
REQ-042 Pack 8 words with WD_OUT_RDY=0 -> FULL=1; send 3 more bytes and present a 4th -> BO=3, PD_IN_RDY=0; pop one -> 4th byte accepted.
REQ-043 Pack AA,BB, then FLUSH -> WD_OUT=AABB0000, BE=1100, FLUSH_DONE one cycle later; FLUSH with BO=0 -> FLUSH_DONE only, no push.
REQ-044 Unpack WD_IN=DEADBEEF with PD_OUT_RDY=1 -> PD_OUT DE,AD,BE,EF on consecutive cycles; EMPTY=1 after EF.
REQ-045 Load 5 words in unpack, toggle DMADIR -> LEVEL=0, BO=0 next cycle, no FLUSH_DONE.
REQ-046 Assert nRESET after 2 packed bytes -> immediate LEVEL=0, BO=0; post-reset, 4 bytes -> one full word.
